// File: rtl/sad_min_search_pkg.sv
`default_nettype none
// ============================================================
// sad_min_search_pkg : shared constants and FSM states for the SAD search
// Revision: 1.0
// ============================================================
package sad_min_search_pkg;

  localparam int DEF_START_DLY = 16;
  localparam int DEF_BLK_PIX   = 256;
  localparam int DEF_NUM_SEG   = 16;
  localparam int DEF_SAD_W     = 16;
  localparam int DEF_IDX_W     = 5;

  // Abs-diff register, accumulate and segment-close stages trail the last sample.
  localparam int c_flush_cyc = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sad_min_search_if.sv
`default_nettype none
// ============================================================
// sad_min_search_if : pixel streams in, search status/result out
// Revision: 1.0
// ============================================================
interface sad_min_search_if #(
  parameter int SAD_W = 16,
  parameter int IDX_W = 5,
  parameter int SEG_W = 4
);
  logic             start;
  logic [7:0]       c;
  logic [7:0]       p;
  logic [7:0]       p_prime;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic [SEG_W-1:0] seg_cnt;

  modport master (
    output start, c, p, p_prime,
    input  busy, done, best_sad, best_idx, seg_cnt
  );

  modport slave (
    input  start, c, p, p_prime,
    output busy, done, best_sad, best_idx, seg_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sad_min_search_lane.sv
`default_nettype none
// ============================================================
// sad_lane : registered |c-p| feeding a saturating accumulator
// Revision: 1.0
// ============================================================
module sad_lane #(
  parameter int SAD_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_vld,
  input  logic             i_first,
  input  logic [7:0]       i_c,
  input  logic [7:0]       i_p,
  output logic [SAD_W-1:0] o_sad
);
  logic [8:0]       w_sub;
  logic [7:0]       w_abs;
  logic [SAD_W:0]   w_sum;
  logic [7:0]       r_diff;
  logic             r_vld;
  logic             r_first;
  logic [SAD_W-1:0] r_acc;

  always_comb begin
    w_sub = {1'b0, i_c} - {1'b0, i_p};
    w_abs = w_sub[8] ? (~w_sub[7:0] + 8'd1) : w_sub[7:0];
    w_sum = {1'b0, r_acc} + {{(SAD_W-7){1'b0}}, r_diff};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_diff  <= 8'd0;
      r_vld   <= 1'b0;
      r_first <= 1'b0;
      r_acc   <= '0;
    end else begin
      r_vld   <= i_vld;
      r_first <= i_first;
      if (i_vld)
        r_diff <= w_abs;
      // First pixel of a segment loads instead of adding, clearing the previous SAD.
      if (r_vld) begin
        if (r_first)
          r_acc <= {{(SAD_W-8){1'b0}}, r_diff};
        else
          r_acc <= w_sum[SAD_W] ? {SAD_W{1'b1}} : w_sum[SAD_W-1:0];
      end
    end
  end

  assign o_sad = r_acc;
endmodule
`default_nettype wire

// File: rtl/sad_min_search.sv
`default_nettype none
// ============================================================
// sad_min_search : two-lane SAD accumulation with running minimum search
// Revision: 1.0
// ============================================================
module sad_min_search
  import sad_min_search_pkg::*;
#(
  parameter int START_DLY = DEF_START_DLY,
  parameter int BLK_PIX   = DEF_BLK_PIX,
  parameter int NUM_SEG   = DEF_NUM_SEG,
  parameter int SAD_W     = DEF_SAD_W,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  sad_min_search_if.slave  bus
);
  localparam int c_pix_w     = clog2_min1(BLK_PIX);
  localparam int c_seg_w     = clog2_min1(NUM_SEG);
  localparam int c_dly_w     = clog2_min1(START_DLY + 1);
  localparam int c_wait_last = (START_DLY >= 2) ? START_DLY - 2 : 0;

  state_t             r_state;
  state_t             w_next;
  logic [c_pix_w-1:0] r_pix;
  logic [c_seg_w-1:0] r_seg;
  logic [c_dly_w-1:0] r_dly;
  logic [1:0]         r_flush;
  logic               w_accept;
  logic               w_sample;
  logic               w_last_pix;
  logic               w_last_smp;

  logic               r_s1_close;
  logic [c_seg_w-1:0] r_s1_seg;
  logic               r_s2_close;
  logic [c_seg_w-1:0] r_s2_seg;

  logic [SAD_W-1:0]   w_sad0;
  logic [SAD_W-1:0]   w_sad1;
  logic [SAD_W-1:0]   w_mid_sad;
  logic [IDX_W-1:0]   w_mid_idx;
  logic [SAD_W-1:0]   w_new_sad;
  logic [IDX_W-1:0]   w_new_idx;
  logic [SAD_W-1:0]   r_best_sad;
  logic [IDX_W-1:0]   r_best_idx;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_sample   = 1'b0;
    w_last_pix = (r_pix == c_pix_w'(BLK_PIX - 1));
    w_last_smp = w_last_pix && (r_seg == c_seg_w'(NUM_SEG - 1));
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (START_DLY == 0) begin
            w_sample = 1'b1;
            w_next   = w_last_smp ? ST_FLUSH : ST_RUN;
          end else if (START_DLY == 1) begin
            w_next = ST_RUN;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_dly == c_dly_w'(c_wait_last))
          w_next = ST_RUN;
      end
      ST_RUN: begin
        w_sample = 1'b1;
        if (w_last_smp)
          w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (r_flush == 2'(c_flush_cyc - 1))
          w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix   <= '0;
      r_seg   <= '0;
      r_dly   <= '0;
      r_flush <= 2'd0;
    end else begin
      r_dly   <= (r_state == ST_WAIT)  ? r_dly + c_dly_w'(1) : '0;
      r_flush <= (r_state == ST_FLUSH) ? r_flush + 2'd1      : 2'd0;
      if (w_sample) begin
        if (w_last_pix) begin
          r_pix <= '0;
          r_seg <= (r_seg == c_seg_w'(NUM_SEG - 1)) ? '0 : r_seg + c_seg_w'(1);
        end else begin
          r_pix <= r_pix + c_pix_w'(1);
        end
      end
    end
  end

  sad_lane #(.SAD_W(SAD_W)) u_lane0 (
    .clk     (clk),
    .reset   (reset),
    .i_vld   (w_sample),
    .i_first (r_pix == '0),
    .i_c     (bus.c),
    .i_p     (bus.p),
    .o_sad   (w_sad0)
  );

  sad_lane #(.SAD_W(SAD_W)) u_lane1 (
    .clk     (clk),
    .reset   (reset),
    .i_vld   (w_sample),
    .i_first (r_pix == '0),
    .i_c     (bus.c),
    .i_p     (bus.p_prime),
    .o_sad   (w_sad1)
  );

  // Segment-close marker travels alongside the two lane stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_close <= 1'b0;
      r_s1_seg   <= '0;
      r_s2_close <= 1'b0;
      r_s2_seg   <= '0;
    end else begin
      r_s1_close <= w_sample && w_last_pix;
      r_s1_seg   <= r_seg;
      r_s2_close <= r_s1_close;
      r_s2_seg   <= r_s1_seg;
    end
  end

  // Even lane first, odd lane against the updated best; strict less keeps earlier ties.
  always_comb begin
    w_mid_sad = r_best_sad;
    w_mid_idx = r_best_idx;
    if (w_sad0 < r_best_sad) begin
      w_mid_sad = w_sad0;
      w_mid_idx = IDX_W'({r_s2_seg, 1'b0});
    end
    w_new_sad = w_mid_sad;
    w_new_idx = w_mid_idx;
    if (w_sad1 < w_mid_sad) begin
      w_new_sad = w_sad1;
      w_new_idx = IDX_W'({r_s2_seg, 1'b1});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_best_sad <= {SAD_W{1'b1}};
      r_best_idx <= '0;
    end else if (w_accept) begin
      r_best_sad <= {SAD_W{1'b1}};
      r_best_idx <= '0;
    end else if (r_s2_close) begin
      r_best_sad <= w_new_sad;
      r_best_idx <= w_new_idx;
    end
  end

  assign bus.busy     = (r_state == ST_WAIT) || (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.best_sad = r_best_sad;
  assign bus.best_idx = r_best_idx;
  assign bus.seg_cnt  = r_seg;
endmodule
`default_nettype wire

// File: tb/tb_sad_min_search.sv
`default_nettype none
// ============================================================
// tb_sad_min_search : scoreboard bench, default and saturation configurations
// Revision: 1.0
// ============================================================
module tb_sad_min_search;
  import sad_min_search_pkg::*;

  localparam int M_DLY = 16;
  localparam int M_BLK = 256;
  localparam int M_SEG = 16;
  localparam int S_DLY = 2;
  localparam int S_BLK = 512;
  localparam int S_SEG = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sad_min_search_if #(.SAD_W(16), .IDX_W(5), .SEG_W(4)) bus   ();
  sad_min_search_if #(.SAD_W(16), .IDX_W(2), .SEG_W(1)) bus_s ();

  sad_min_search #(.START_DLY(M_DLY), .BLK_PIX(M_BLK), .NUM_SEG(M_SEG), .SAD_W(16), .IDX_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sad_min_search #(.START_DLY(S_DLY), .BLK_PIX(S_BLK), .NUM_SEG(S_SEG), .SAD_W(16), .IDX_W(2)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  typedef struct {
    int sad;
    int idx;
    int cyc;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];
  int   checks = 0;
  int   errors = 0;
  int   last_done = 0;
  logic [7:0] ac[];
  logic [7:0] ap[];
  logic [7:0] app[];

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic drive(input int which, input logic st, input logic [7:0] cv, input logic [7:0] pv, input logic [7:0] ppv);
    if (which == 0) begin
      bus.start = st; bus.c = cv; bus.p = pv; bus.p_prime = ppv;
      bus_s.start = 1'b0;
    end else begin
      bus_s.start = st; bus_s.c = cv; bus_s.p = pv; bus_s.p_prime = ppv;
      bus.start = 1'b0;
    end
  endtask

  // Stimulus patterns: 0 identical, 1 single match, 2 odd-lane tie, 3 random, 4 near-match, 5 saturating.
  task automatic gen(input int mode, input int blk, input int nseg);
    int n;
    int s;
    n = blk * nseg;
    ac = new[n]; ap = new[n]; app = new[n];
    for (int i = 0; i < n; i++) begin
      s = i / blk;
      case (mode)
        0: begin ac[i] = 8'h40; ap[i] = 8'h40; app[i] = 8'h40; end
        1: begin ac[i] = 8'h10; ap[i] = (s == 5) ? 8'h10 : 8'h20; app[i] = 8'h30; end
        2: begin
          ac[i]  = 8'($urandom_range(0, 252));
          ap[i]  = ac[i] + 8'd2;
          app[i] = (s == 3 || s == 7) ? ac[i] + 8'd1 : ac[i] + 8'd3;
        end
        4: begin
          ac[i]  = 8'($urandom_range(0, 240));
          ap[i]  = ac[i] + 8'($urandom_range(0, 15));
          app[i] = ac[i] + 8'($urandom_range(0, 15));
        end
        5: begin ac[i] = 8'h00; ap[i] = 8'hFF; app[i] = 8'hFF; end
        default: begin ac[i] = 8'($urandom); ap[i] = 8'($urandom); app[i] = 8'($urandom); end
      endcase
    end
  endtask

  // Candidate 2s uses p, 2s+1 uses p_prime; lowest index wins among equal minima.
  task automatic model(input int blk, input int nseg, output int bsad, output int bidx);
    int sum;
    int d;
    bsad = 65535;
    bidx = 0;
    for (int cand = 0; cand < 2 * nseg; cand++) begin
      sum = 0;
      for (int k = 0; k < blk; k++) begin
        d = (cand % 2 == 0) ? int'(ac[(cand/2)*blk + k]) - int'(ap[(cand/2)*blk + k])
                            : int'(ac[(cand/2)*blk + k]) - int'(app[(cand/2)*blk + k]);
        sum += (d < 0) ? -d : d;
      end
      if (sum > 65535) sum = 65535;
      if (sum < bsad) begin
        bsad = sum;
        bidx = cand;
      end
    end
  endtask

  // Called one step after a rising edge; that cycle is the start cycle.
  task automatic run_search(input int which, input int mode, input int extra_r, input int abort_r);
    int   d, blk, nseg, n, t0;
    exp_t e;
    d    = (which == 0) ? M_DLY : S_DLY;
    blk  = (which == 0) ? M_BLK : S_BLK;
    nseg = (which == 0) ? M_SEG : S_SEG;
    n    = blk * nseg;
    t0   = cyc;
    gen(mode, blk, nseg);
    if (abort_r < 0) begin
      model(blk, nseg, e.sad, e.idx);
      e.cyc = t0 + d + n + 3;
      if (which == 0) q_m.push_back(e); else q_s.push_back(e);
      last_done = e.cyc;
    end
    for (int r = 0; r < d + n; r++) begin
      if (r >= d)
        drive(which, (r == 0) || (r == extra_r), ac[r-d], ap[r-d], app[r-d]);
      else
        drive(which, (r == 0) || (r == extra_r), 8'($urandom), 8'($urandom), 8'($urandom));
      if (r == abort_r) reset = 1'b1;
      @(posedge clk); #1;
      if (which == 0 && r + 1 == d + 3 * blk + 7) begin
        check("mid_seg_cnt", int'(bus.seg_cnt), 3);
        check("mid_busy", int'(bus.busy), 1);
      end
      if (r == abort_r) begin
        reset = 1'b0;
        drive(which, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_best_sad", int'(bus.best_sad), 65535);
        check("abort_best_idx", int'(bus.best_idx), 0);
        check("abort_seg_cnt", int'(bus.seg_cnt), 0);
        return;
      end
    end
    drive(which, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  logic m_prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done) begin
      if (q_m.size() == 0) begin
        check("main_unexpected_done", 1, 0);
      end else begin
        e = q_m.pop_front();
        check("main_best_sad", int'(bus.best_sad), e.sad);
        check("main_best_idx", int'(bus.best_idx), e.idx);
        check("main_done_cycle", cyc, e.cyc);
        check("main_busy_before_done", int'(m_prev_busy), 1);
      end
    end
    m_prev_busy = bus.busy;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus_s.done) begin
      if (q_s.size() == 0) begin
        check("sat_unexpected_done", 1, 0);
      end else begin
        e = q_s.pop_front();
        check("sat_best_sad", int'(bus_s.best_sad), e.sad);
        check("sat_best_idx", int'(bus_s.best_idx), e.idx);
        check("sat_done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    drive(0, 1'b0, 8'd0, 8'd0, 8'd0);
    drive(1, 1'b0, 8'd0, 8'd0, 8'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_best_sad", int'(bus.best_sad), 65535);
    check("rst_best_idx", int'(bus.best_idx), 0);
    check("rst_seg_cnt", int'(bus.seg_cnt), 0);
    check("rst_s_best_sad", int'(bus_s.best_sad), 65535);

    run_search(0, 0, -1, -1);            wait_cycle(last_done + 1);
    run_search(0, 1, -1, -1);            wait_cycle(last_done + 1);
    run_search(0, 2, -1, -1);            wait_cycle(last_done + 1);
    run_search(0, 3, M_DLY + 100, -1);   wait_cycle(last_done + 1);
    run_search(0, 3, -1, M_DLY + 1000);
    repeat (2) begin @(posedge clk); #1; end
    run_search(0, 3, -1, -1);            wait_cycle(last_done + 1);

    // Start held over the done cycle and the next: only the second is accepted.
    run_search(0, 0, -1, -1);
    wait_cycle(last_done);
    drive(0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    @(posedge clk); #1;
    run_search(0, 3, -1, -1);            wait_cycle(last_done + 1);
    run_search(0, 4, -1, -1);            wait_cycle(last_done + 1);

    run_search(1, 5, -1, -1);            wait_cycle(last_done + 1);
    run_search(1, 3, -1, -1);            wait_cycle(last_done + 1);

    for (int i = 0; i < 40 && (q_m.size() != 0 || q_s.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    if (q_m.size() != 0 || q_s.size() != 0) begin
      check("drain_timeout_pending", q_m.size() + q_s.size(), 0);
      q_m.delete();
      q_s.delete();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
